// File: rtl/awb_gain_scheduler.sv
// awb_gain_scheduler
// ------------------
// Auto-white-balance gain scheduler. At each frame_end it latches the
// per-channel frame sums and the enable bit. It forms the grey-world target
// and issues three divisions (R, G, B) to a shared fixed-latency divider. It
// captures each quotient after DIV_LATENCY cycles. The resulting gains are
// held in shadow registers until the next frame_start, where they are
// committed.
//
// Optional build macro: AWB_GAIN_CLAMP_EN clamps each computed gain to
// [0.5, 4.0] in GAIN_FRAC fixed point. Without it, only GAIN_WIDTH
// saturation applies.
//
// Ports
//   clk, reset       : single clock, synchronous active-high reset
//   enable           : AWB enable, sampled together with an accepted frame_end
//   frame_end        : one-cycle pulse, sum_r/g/b are final
//   frame_start      : one-cycle pulse, commit point for pending gains
//   sum_r/g/b        : frame sums (sum_g holds both green sites)
//   div_valid        : divider issue strobe
//   div_dividend     : divider operand, grey level << GAIN_FRAC
//   div_divisor      : divider operand, 3 * channel sum
//   div_quotient     : divider result, valid DIV_LATENCY cycles after issue
//   gain_r/g/b       : active gains (unity = 1 << GAIN_FRAC)
//   gain_update      : one-cycle pulse when new gains are committed
//   busy             : high whenever the scheduler is not idle
//   overrun          : sticky, set when a frame_end is dropped
module awb_gain_scheduler #(
    parameter int SUM_WIDTH   = 40,
    parameter int GAIN_FRAC   = 8,
    parameter int GAIN_WIDTH  = 16,
    parameter int DIV_LATENCY = 20
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           frame_end,
    input  logic                           frame_start,
    input  logic [SUM_WIDTH-1:0]           sum_r,
    input  logic [SUM_WIDTH-1:0]           sum_g,
    input  logic [SUM_WIDTH-1:0]           sum_b,
    output logic                           div_valid,
    output logic [SUM_WIDTH+GAIN_FRAC+1:0] div_dividend,
    output logic [SUM_WIDTH+1:0]           div_divisor,
    input  logic [SUM_WIDTH+GAIN_FRAC+1:0] div_quotient,
    output logic [GAIN_WIDTH-1:0]          gain_r,
    output logic [GAIN_WIDTH-1:0]          gain_g,
    output logic [GAIN_WIDTH-1:0]          gain_b,
    output logic                           gain_update,
    output logic                           busy,
    output logic                           overrun
);

    localparam int DW = SUM_WIDTH + 2;          // divisor / grey width
    localparam int QW = DW + GAIN_FRAC;         // dividend / quotient width
    localparam int CW = $clog2(DIV_LATENCY + 3);

    // Cycle counter runs from the first issue (0) to the B capture.
    localparam logic [CW-1:0] CAP_R      = CW'(DIV_LATENCY);
    localparam logic [CW-1:0] CAP_G      = CW'(DIV_LATENCY + 1);
    localparam logic [CW-1:0] CAP_B      = CW'(DIV_LATENCY + 2);
    localparam logic [CW-1:0] LAST_ISSUE = CW'(2);

    localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(1) << GAIN_FRAC;

`ifdef AWB_GAIN_CLAMP_EN
    localparam logic [QW-1:0] CLAMP_LO = QW'(1) << (GAIN_FRAC - 1);
    localparam logic [QW-1:0] CLAMP_HI = QW'(4) << GAIN_FRAC;
`endif

    typedef enum logic [2:0] {IDLE, LATCH, ISSUE, WAIT, PEND} state_t;

    state_t                  state, state_next;
    logic [SUM_WIDTH-1:0]    lat_r, lat_b;
    logic [SUM_WIDTH-2:0]    lat_half_g;    // sum_g >> 1: average of the two greens
    logic                    lat_en;
    logic [DW-1:0]           gray;
    logic [DW-1:0]           div_r, div_g, div_b;
    logic [CW-1:0]           cnt;
    logic [GAIN_WIDTH-1:0]   shadow_r, shadow_g, shadow_b;

    // Map a raw quotient to a gain. A zero divisor or a disabled frame yields
    // unity. In that case the quotient is ignored, but the divider slot is
    // still used so latency is identical.
    function automatic logic [GAIN_WIDTH-1:0] chan_gain(
        input logic [QW-1:0] q,
        input logic [DW-1:0] d,
        input logic          en
    );
        logic [QW-1:0] g;
        if (!en || d == '0)
            return UNITY;
        g = q;
`ifdef AWB_GAIN_CLAMP_EN
        if (g > CLAMP_HI)
            g = CLAMP_HI;
        else if (g < CLAMP_LO)
            g = CLAMP_LO;
`endif
        if (|(g >> GAIN_WIDTH))
            return '1;
        return GAIN_WIDTH'(g);
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        // NOTE: every register, including the datapath and shadow copies, is
        // reset. An aborted computation therefore leaves nothing stale behind.
        if (reset) begin
            state       <= IDLE;
            lat_r       <= '0;
            lat_half_g  <= '0;
            lat_b       <= '0;
            lat_en      <= 1'b0;
            gray        <= '0;
            div_r       <= '0;
            div_g       <= '0;
            div_b       <= '0;
            cnt         <= '0;
            shadow_r    <= '0;
            shadow_g    <= '0;
            shadow_b    <= '0;
            gain_r      <= UNITY;
            gain_g      <= UNITY;
            gain_b      <= UNITY;
            gain_update <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_next;
            gain_update <= 1'b0;

            // Only IDLE accepts a frame_end; anywhere else it is dropped.
            if (frame_end && state != IDLE)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (frame_end) begin
                        lat_r      <= sum_r;
                        lat_half_g <= sum_g[SUM_WIDTH-1:1];
                        lat_b      <= sum_b;
                        lat_en     <= enable;
                    end
                end
                LATCH: begin
                    gray  <= DW'(lat_r) + DW'(lat_half_g) + DW'(lat_b);
                    div_r <= DW'(lat_r) + DW'({lat_r, 1'b0});
                    div_g <= DW'(lat_half_g) + DW'({lat_half_g, 1'b0});
                    div_b <= DW'(lat_b) + DW'({lat_b, 1'b0});
                    cnt   <= '0;
                end
                ISSUE, WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CAP_R) shadow_r <= chan_gain(div_quotient, div_r, lat_en);
                    if (cnt == CAP_G) shadow_g <= chan_gain(div_quotient, div_g, lat_en);
                    if (cnt == CAP_B) shadow_b <= chan_gain(div_quotient, div_b, lat_en);
                end
                PEND: begin
                    if (frame_start) begin
                        gain_r      <= shadow_r;
                        gain_g      <= shadow_g;
                        gain_b      <= shadow_b;
                        gain_update <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        div_valid    = 1'b0;
        div_dividend = '0;
        div_divisor  = '0;
        busy         = (state != IDLE);

        case (state)
            IDLE:  if (frame_end) state_next = LATCH;
            LATCH: state_next = ISSUE;
            ISSUE: begin
                div_valid    = 1'b1;
                div_dividend = {gray, {GAIN_FRAC{1'b0}}};
                if (cnt == '0)
                    div_divisor = div_r;
                else if (cnt == CW'(1))
                    div_divisor = div_g;
                else
                    div_divisor = div_b;
                if (cnt == CAP_B)
                    state_next = PEND;
                else if (cnt == LAST_ISSUE)
                    state_next = WAIT;
            end
            WAIT:  if (cnt == CAP_B) state_next = PEND;
            PEND:  if (frame_start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_awb_gain_scheduler.sv
// Testbench for awb_gain_scheduler: directed frame vectors with hand-computed
// gains, plus hand-written sequences for overrun, mid-computation reset and
// coincident frame_end / frame_start.
module tb_awb_gain_scheduler;

    localparam int SW = 40;
    localparam int GF = 8;
    localparam int GW = 16;
    localparam int L  = 20;
    localparam int DW = SW + 2;
    localparam int QW = DW + GF;
    localparam int JUNK = 777;      // divider output on cycles with no result

`ifdef AWB_GAIN_CLAMP_EN
    localparam int EXT_R = 1024;
    localparam int SAT_R = 1024;
    localparam int LOW_R = 128;
`else
    localparam int EXT_R = 17152;
    localparam int SAT_R = 65535;
    localparam int LOW_R = 106;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          frame_end = 1'b0;
    logic          frame_start = 1'b0;
    logic [SW-1:0] sum_r = '0;
    logic [SW-1:0] sum_g = '0;
    logic [SW-1:0] sum_b = '0;
    logic          div_valid;
    logic [QW-1:0] div_dividend;
    logic [DW-1:0] div_divisor;
    logic [QW-1:0] div_quotient;
    logic [GW-1:0] gain_r, gain_g, gain_b;
    logic          gain_update, busy, overrun;

    awb_gain_scheduler #(
        .SUM_WIDTH  (SW),
        .GAIN_FRAC  (GF),
        .GAIN_WIDTH (GW),
        .DIV_LATENCY(L)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .frame_end   (frame_end),
        .frame_start (frame_start),
        .sum_r       (sum_r),
        .sum_g       (sum_g),
        .sum_b       (sum_b),
        .div_valid   (div_valid),
        .div_dividend(div_dividend),
        .div_divisor (div_divisor),
        .div_quotient(div_quotient),
        .gain_r      (gain_r),
        .gain_g      (gain_g),
        .gain_b      (gain_b),
        .gain_update (gain_update),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Fixed-latency divider model. A result issued in cycle n is presented
    // during cycle n+L. All other cycles carry a junk value.
    logic [QW-1:0] pipe [L];
    always @(posedge clk) begin
        if (div_valid)
            pipe[0] <= (div_divisor == '0) ? '1 : div_dividend / QW'(div_divisor);
        else
            pipe[0] <= QW'(JUNK);
        for (int i = 1; i < L; i++)
            pipe[i] <= pipe[i-1];
    end
    assign div_quotient = pipe[L-1];

    int checks = 0;
    int errors = 0;
    bit exp_ovr = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        string         name;
        logic          en;
        logic [SW-1:0] r, g, b;
        int            er, eg, eb;
        int            start;       // cycle (after frame_end) of frame_start
    } vec_t;

    // One frame: frame_end in cycle 0, frame_start in cycle v.start. Also
    // applies a frame_start in cycle 8 (outside PEND, must be ignored). It
    // optionally applies a second frame_end in cycle fe2, or a frame_start
    // together with the first frame_end.
    task automatic run_frame(input vec_t v, input int fe2, input bit fs_with_fe);
        logic [GW-1:0] pr, pg, pb;
        int dv_bad, busy_bad, upd_bad, hold_bad;
        dv_bad = 0; busy_bad = 0; upd_bad = 0; hold_bad = 0;
        @(negedge clk);
        check({v.name, " idle busy"}, busy, 0);
        pr = gain_r; pg = gain_g; pb = gain_b;
        sum_r = v.r; sum_g = v.g; sum_b = v.b; enable = v.en;
        frame_end = 1'b1; frame_start = fs_with_fe;
        for (int c = 1; c <= v.start; c++) begin
            @(negedge clk);
            frame_end = 1'b0; frame_start = 1'b0;
            if (c == 1) begin
                // Inputs change after acceptance; only latched values may matter.
                sum_r = 40'd12345; sum_g = 40'd7; sum_b = 40'd999; enable = ~v.en;
            end
            if (div_valid !== (c >= 2 && c <= 4)) dv_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (gain_update !== 1'b0) upd_bad++;
            if (gain_r !== pr || gain_g !== pg || gain_b !== pb) hold_bad++;
            if (c == 8) frame_start = 1'b1;
            if (c == fe2) begin
                frame_end = 1'b1; sum_r = 40'd1000; sum_g = 40'd2000; sum_b = 40'd1000;
                exp_ovr = 1'b1;
            end
            if (c == v.start) frame_start = 1'b1;
        end
        @(negedge clk);
        frame_end = 1'b0; frame_start = 1'b0;
        check({v.name, " div_valid window"}, dv_bad, 0);
        check({v.name, " busy window"}, busy_bad, 0);
        check({v.name, " no early update"}, upd_bad, 0);
        check({v.name, " gains held"}, hold_bad, 0);
        check({v.name, " gain_update"}, gain_update, 1);
        check({v.name, " gain_r"}, gain_r, v.er);
        check({v.name, " gain_g"}, gain_g, v.eg);
        check({v.name, " gain_b"}, gain_b, v.eb);
        check({v.name, " busy after"}, busy, 0);
        check({v.name, " overrun"}, overrun, exp_ovr);
        @(negedge clk);
        check({v.name, " update pulse"}, gain_update, 0);
    endtask

    vec_t vecs[7];
    vec_t v_cast, v_zero, v_ext;

    initial begin
        vecs[0] = '{"balanced", 1'b1, 40'd1000, 40'd2000, 40'd1000, 256, 256, 256, 30};
        vecs[1] = '{"cast",     1'b1, 40'd500,  40'd2000, 40'd1000, 426, 213, 213, 27};
        vecs[2] = '{"extreme",  1'b1, 40'd10,   40'd2000, 40'd1000, EXT_R, 171, 171, 27};
        vecs[3] = '{"zero_r",   1'b1, 40'd0,    40'd2000, 40'd1000, 256, 170, 170, 27};
        vecs[4] = '{"disabled", 1'b0, 40'd500,  40'd2000, 40'd1000, 256, 256, 256, 27};
        vecs[5] = '{"saturate", 1'b1, 40'd1,    40'd2000, 40'd1000, SAT_R, 170, 170, 27};
        vecs[6] = '{"low",      1'b1, 40'd8000, 40'd2000, 40'd1000, LOW_R, 853, 853, 27};
        v_cast = vecs[1];
        v_zero = vecs[3];
        v_ext  = vecs[2];

        // Reset state.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst gain_r", gain_r, 256);
        check("rst gain_g", gain_g, 256);
        check("rst gain_b", gain_b, 256);
        check("rst busy", busy, 0);
        check("rst div_valid", div_valid, 0);
        check("rst div_dividend", div_dividend, 0);
        check("rst div_divisor", div_divisor, 0);
        check("rst gain_update", gain_update, 0);
        check("rst overrun", overrun, 0);

        for (int i = 0; i < 7; i++)
            run_frame(vecs[i], 0, 1'b0);

        // Second frame_end in cycle 10: dropped, overrun set, first frame's gains.
        v_cast.name = "overrun";
        run_frame(v_cast, 10, 1'b0);

        // Reset in cycle 12 of a computation.
        begin
            int quiet_bad;
            quiet_bad = 0;
            @(negedge clk);
            sum_r = 40'd500; sum_g = 40'd2000; sum_b = 40'd1000; enable = 1'b1;
            frame_end = 1'b1;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                frame_end = 1'b0;
                if (c == 12) reset = 1'b1;
            end
            @(negedge clk);
            reset = 1'b0;
            exp_ovr = 1'b0;
            check("midrst busy", busy, 0);
            check("midrst overrun", overrun, 0);
            check("midrst gain_r", gain_r, 256);
            check("midrst gain_g", gain_g, 256);
            check("midrst gain_b", gain_b, 256);
            for (int c = 0; c < L + 10; c++) begin
                @(negedge clk);
                if (gain_update !== 1'b0 || busy !== 1'b0 || div_valid !== 1'b0) quiet_bad++;
            end
            check("midrst stays idle", quiet_bad, 0);
        end
        v_zero.name = "after_reset";
        run_frame(v_zero, 0, 1'b0);

        // frame_end together with frame_start in PEND: commit, drop, overrun.
        v_cast.name = "pend_coincide";
        run_frame(v_cast, v_cast.start, 1'b0);

        // frame_end together with frame_start in IDLE: frame accepted, start ignored.
        v_ext.name = "idle_coincide";
        run_frame(v_ext, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
